// File: rtl/mux_scan_pkg.sv
// Shared constants, FSM state encoding and helpers for the mux scan controller.
// Optional macro MUX_SCAN_MAJORITY_EN enables 3-sample majority voting in the top.
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational search for the next set mask bit above an index, or the
// lowest set bit when fromStart is asserted.
import mux_scan_pkg::*;

module mux_scan_next_ch (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  idx_i,
    input  logic              from_start_i,
    output logic [SEL_W-1:0]  idx_o,
    output logic              found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found_o && mask_i[i] && (from_start_i || (i > int'(idx_i)))) begin
                idx_o   = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled inputs of a downstream 8:1 mux and hands off a frame.
// Define MUX_SCAN_MAJORITY_EN for a 3-cycle majority-voted sample per channel.
import mux_scan_pkg::*;

module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] chan_mask,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [NUM_CH-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]   frame_q, frame_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [3:0]          cnt_q, cnt_d;

    logic [NUM_CH-1:0]   first_mask;
    logic [SEL_W-1:0]    first_idx, next_idx;
    logic                first_found, next_found;
    logic                sample_bit, sample_last;

`ifdef MUX_SCAN_MAJORITY_EN
    logic [1:0]          smp_cnt_q, smp_cnt_d;
    logic [1:0]          smp_q, smp_d;
`endif

    // In IDLE the live mask picks the first channel; afterwards only the latched copy matters.
    assign first_mask = (state_q == ST_IDLE) ? chan_mask : mask_q;

    mux_scan_next_ch u_first (
        .mask_i       (first_mask),
        .idx_i        ('0),
        .from_start_i (1'b1),
        .idx_o        (first_idx),
        .found_o      (first_found)
    );

    mux_scan_next_ch u_next (
        .mask_i       (mask_q),
        .idx_i        (sel_q),
        .from_start_i (1'b0),
        .idx_o        (next_idx),
        .found_o      (next_found)
    );

`ifdef MUX_SCAN_MAJORITY_EN
    assign sample_bit  = maj3(smp_q[0], smp_q[1], mux_out);
    assign sample_last = (smp_cnt_q == 2'd2);
`else
    assign sample_bit  = mux_out;
    assign sample_last = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
`ifdef MUX_SCAN_MAJORITY_EN
        smp_cnt_d = smp_cnt_q;
        smp_d     = smp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && (chan_mask != '0)) begin
                    mask_d   = chan_mask;
                    sel_d    = first_idx;
                    shadow_d = '0;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
`ifdef MUX_SCAN_MAJORITY_EN
                    smp_cnt_d = 2'd0;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (sample_last) begin
                    // The final bit is folded in here so the frame captured on DONE entry is complete.
                    shadow_d[sel_q] = sample_bit;
                    if (next_found) begin
                        sel_d   = next_idx;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        frame_d = shadow_d;
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
`ifdef MUX_SCAN_MAJORITY_EN
                else begin
                    smp_d[smp_cnt_q[0]] = mux_out;
                    smp_cnt_d           = smp_cnt_q + 2'd1;
                end
`endif
            end
            ST_DONE: begin
                if (frame_ready) begin
                    valid_d = 1'b0;
                    if (CONTINUOUS && first_found) begin
                        sel_d    = first_idx;
                        shadow_d = '0;
                        cnt_d    = CNT_LOAD;
                        state_d  = ST_SETTLE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef MUX_SCAN_MAJORITY_EN
            smp_cnt_q <= '0;
            smp_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
`ifdef MUX_SCAN_MAJORITY_EN
            smp_cnt_q <= smp_cnt_d;
            smp_q     <= smp_d;
`endif
        end
    end

    assign sel         = sel_q;
    assign busy        = busy_q;
    assign frame       = frame_q;
    assign frame_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 8:1 mux in front of it.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_MAJORITY_EN
    localparam int PER_CH = 5;
`else
    localparam int PER_CH = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] chan_mask = '0;
    logic       mux_out;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] frame;
    logic       frame_valid;
    logic       frame_ready = 1'b0;

    logic [7:0] mux_in = '0;
    logic       glitch_en = 1'b0;
    logic       glitch_val = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Channel 2 can be made to toggle every cycle it is selected, starting at 1.
    always @(posedge clk) begin
        if (sel != 3'd2) glitch_val <= 1'b1;
        else             glitch_val <= ~glitch_val;
    end

    assign mux_out = (glitch_en && sel == 3'd2) ? glitch_val : mux_in[sel];

    mux_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .chan_mask   (chan_mask),
        .mux_out     (mux_out),
        .sel         (sel),
        .busy        (busy),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] m);
        chan_mask = m;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Runs until frame_valid, returning latency in edges after acceptance and the sel visit order.
    task automatic run_scan(output int cyc, output logic [2:0] visits[$]);
        logic [2:0] last;
        visits.delete();
        cyc = 0;
        visits.push_back(sel);
        last = sel;
        while (!frame_valid && cyc < 200) begin
            tick();
            cyc++;
            if (!frame_valid && sel !== last) begin
                visits.push_back(sel);
                last = sel;
            end
        end
    endtask

    task automatic handoff();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (sel !== 3'd0 || busy !== 1'b0 || frame !== 8'h00 || frame_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state sel=%0d busy=%b frame=%h fv=%b required 0/0/00/0",
                     sel, busy, frame, frame_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_scan();
        int cyc;
        logic [2:0] v[$];
        mux_in = 8'hA5;
        pulse_start(8'hFF);
        checks++;
        if (busy !== 1'b1 || sel !== 3'd0) begin
            errors++;
            $display("[TB] FAIL full_accept busy=%b sel=%0d required 1/0", busy, sel);
        end
        run_scan(cyc, v);
        checks++;
        if (cyc !== 8 * PER_CH) begin
            errors++;
            $display("[TB] FAIL full_latency got %0d required %0d", cyc, 8 * PER_CH);
        end
        checks++;
        if (frame !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL full_frame got %h required a5", frame);
        end
        checks++;
        if (v.size() != 8) begin
            errors++;
            $display("[TB] FAIL full_sel_count got %0d required 8", v.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i] !== 3'(i)) begin
                    errors++;
                    $display("[TB] FAIL full_sel_order idx %0d got %0d required %0d", i, v[i], i);
                    break;
                end
            end
        end
        handoff();
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_handoff fv=%b busy=%b required 0/0", frame_valid, busy);
        end
    endtask

    task automatic test_sparse_mask();
        int cyc;
        logic [2:0] v[$];
        mux_in = 8'hFF;
        pulse_start(8'h81);
        run_scan(cyc, v);
        checks++;
        if (cyc !== 2 * PER_CH) begin
            errors++;
            $display("[TB] FAIL sparse_latency got %0d required %0d", cyc, 2 * PER_CH);
        end
        checks++;
        if (frame !== 8'h81) begin
            errors++;
            $display("[TB] FAIL sparse_frame got %h required 81", frame);
        end
        checks++;
        if (v.size() != 2 || v[0] !== 3'd0 || v[1] !== 3'd7) begin
            errors++;
            $display("[TB] FAIL sparse_sel_visits count %0d required 2 visits 0 then 7", v.size());
        end
        checks++;
        if (sel !== 3'd7) begin
            errors++;
            $display("[TB] FAIL sparse_sel_hold_done got %0d required 7", sel);
        end
        handoff();
        tick();
        checks++;
        if (sel !== 3'd7 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sparse_sel_hold_idle sel=%0d busy=%b required 7/0", sel, busy);
        end
    endtask

    task automatic test_zero_mask();
        logic seen;
        seen = 1'b0;
        pulse_start(8'h00);
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0 || frame_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL zero_mask busy=%b fv=%b required idle", busy, frame_valid);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0] held;
        logic bad;
        mux_in = 8'h3C;
        pulse_start(8'hFF);
        repeat (4) tick();
        chan_mask   = 8'h01;
        start       = 1'b1;
        frame_ready = 1'b1;
        tick();
        tick();
        start       = 1'b0;
        frame_ready = 1'b0;
        cyc = 6;
        while (!frame_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 8 * PER_CH) begin
            errors++;
            $display("[TB] FAIL busy_start_latency got %0d required %0d", cyc, 8 * PER_CH);
        end
        checks++;
        if (frame !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL busy_start_frame got %h required 3c", frame);
        end
        held = frame;
        bad  = 1'b0;
        mux_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (frame !== held || frame_valid !== 1'b1 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL done_hold frame=%h fv=%b busy=%b required 3c/1/1", frame, frame_valid, busy);
        end
        handoff();
        checks++;
        if (frame_valid !== 1'b0 || frame !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL done_release fv=%b frame=%h required 0/3c", frame_valid, frame);
        end
    endtask

    task automatic test_reset_mid_scan();
        int guard;
        logic seen;
        mux_in = 8'hFF;
        pulse_start(8'hFF);
        guard = 0;
        while (sel !== 3'd3 && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (sel !== 3'd3) begin
            errors++;
            $display("[TB] FAIL midreset_reach_sel3 got %0d required 3", sel);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (sel !== 3'd0 || busy !== 1'b0 || frame !== 8'h00 || frame_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state sel=%0d busy=%b frame=%h fv=%b required 0/0/00/0",
                     sel, busy, frame, frame_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (frame_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL midreset_no_frame fv=%b busy=%b required 0/0", frame_valid, busy);
        end
    endtask

`ifdef MUX_SCAN_MAJORITY_EN
    task automatic test_majority();
        int cyc;
        logic [2:0] v[$];
        mux_in    = 8'h00;
        glitch_en = 1'b1;
        pulse_start(8'hFF);
        run_scan(cyc, v);
        glitch_en = 1'b0;
        checks++;
        if (frame !== 8'h04) begin
            errors++;
            $display("[TB] FAIL majority_frame got %h required 04", frame);
        end
        checks++;
        if (cyc !== 40) begin
            errors++;
            $display("[TB] FAIL majority_latency got %0d required 40", cyc);
        end
        handoff();
    endtask
`endif

    initial begin
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef MUX_SCAN_MAJORITY_EN
        test_majority();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2: settle cycles after each sel change before sampling; legal range 1..15.
REQ-002 Parameter CONTINUOUS, default 0: 1 restarts a scan automatically after each frame handoff.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one scan; sampled only in IDLE.
REQ-006 chan_mask  input  8  channels to scan, bit i = mux input i; latched when start is accepted.
REQ-007 mux_out  input  1  output of the downstream 8:1 mux being scanned.
REQ-008 sel  output  3  registered select driven to the 8:1 mux.
REQ-009 busy  output  1  high from start acceptance until the frame is handed off.
REQ-010 frame  output  8  captured samples, bit i = value of mux input i.
REQ-011 frame_valid  output  1  frame holds a complete result.
REQ-012 frame_ready  input  1  consumer accepts the frame when high with frame_valid.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE: start=1 with chan_mask!=0 SHALL latch mask, set sel to the lowest set bit, clear shadow register, set busy, load settle counter, and go to SETTLE.
REQ-015 IDLE: start=1 with chan_mask==0 SHALL be ignored; the FSM stays in IDLE with busy low.
REQ-016 SETTLE SHALL last exactly SETTLE_CYC cycles with sel stable, then go to SAMPLE.
REQ-017 SAMPLE (single cycle without macro) SHALL write mux_out into shadow bit [sel].
REQ-018 After SAMPLE, if a set mask bit exists above sel, sel SHALL move to the next higher set bit and the FSM returns to SETTLE; otherwise it goes to DONE.
REQ-019 Bits of unmasked channels SHALL read 0 in frame; unmasked channels are never selected.
REQ-020 On entry to DONE, frame SHALL load the shadow register and frame_valid SHALL rise on the cycle after the last SAMPLE cycle.
REQ-021 Each enabled channel SHALL cost SETTLE_CYC+1 cycles; mask 0xFF with SETTLE_CYC=2 gives frame_valid 24 cycles after start acceptance.
REQ-022 DONE: frame and frame_valid SHALL hold until frame_ready=1; on that edge frame_valid falls and busy falls (CONTINUOUS=0, go to IDLE).
REQ-023 CONTINUOUS=1: the handoff edge SHALL restart the scan with the still-latched mask, keeping busy high; frame retains its value with frame_valid low.
REQ-024 start during busy and frame_ready without frame_valid SHALL be ignored.
REQ-025 chan_mask changes after acceptance SHALL NOT affect the running scan.
REQ-026 sel SHALL hold its last value in IDLE and DONE.

Reset
REQ-027 rst=1 SHALL force IDLE, sel=0, busy=0, frame=0, frame_valid=0, and clear the latched mask and shadow register.
REQ-028 Reset mid-scan or in DONE SHALL abort with no frame produced; the pending frame is discarded.

Configuration
REQ-029 Macro MUX_SCAN_MAJORITY_EN defined: SAMPLE SHALL last 3 cycles and store the 2-of-3 majority of mux_out; per-channel cost becomes SETTLE_CYC+3.
REQ-030 MUX_SCAN_MAJORITY_EN undefined: SAMPLE SHALL be a single cycle and the majority logic is absent.

Structure
REQ-031 Package mux_scan_pkg SHALL hold NUM_CH=8, SEL_W=3, and the FSM state typedef.
REQ-032 Sub-module mux_scan_next_ch (combinational) SHALL return the next set mask bit above a given index plus a found flag; it is also used to pick the first channel.

Verification
REQ-033 Mask 0xFF, SETTLE_CYC=2, mux inputs 8'hA5 -> frame=8'hA5, frame_valid rises 24 cycles after start, sel steps 0..7.
REQ-034 Mask 8'h81, inputs 8'hFF -> sel visits only 0 then 7; frame=8'h81 after 6 cycles.
REQ-035 Mask 0x00 with start -> busy stays low and frame_valid never rises.
REQ-036 frame_ready held low 10 cycles in DONE -> frame stable and busy high; ready=1 -> frame_valid=0 next cycle; start during the scan is ignored.
REQ-037 rst asserted mid-scan at sel=3 -> next cycle sel=0, busy=0, frame=0, frame_valid=0, and no frame appears.
REQ-038 MUX_SCAN_MAJORITY_EN, channel 2 glitching 1,0,1 over the sample cycles -> frame[2]=1, and mask 0xFF frame_valid arrives at 40 cycles.
